// File: rtl/bus_term_fifo.sv
// Per-terminal bus adapter: a TX FIFO from the driver toward the bus and an RX FIFO from the bus
// toward the monitor. Each FIFO counts the writes it rejects, and accepted RX pushes are checked against id.

module term_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             vld,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count, count_nxt, count_after_rd;
  logic [W-1:0]  head_q, head_nxt;
  logic          rd_acc, wr_acc;

  assign full = (count == FULL_CNT);
  assign vld  = (count != '0);
  assign head = head_q;

  // A write into a full FIFO still lands if a read frees the head slot in the same cycle.
  always_comb begin
    rd_acc         = rd_en && (count != '0);
    wr_acc         = wr_en && (!full || rd_acc);
    rd_ptr_nxt     = rd_acc ? rd_ptr + AW'(1) : rd_ptr;
    count_after_rd = count - (AW+1)'(rd_acc);
    count_nxt      = count_after_rd + (AW+1)'(wr_acc);
    head_nxt       = '0;
    if (count_nxt != '0)
      head_nxt = (count_after_rd == '0) ? wr_data : mem[rd_ptr_nxt];
  end

  // NOTE: the storage array carries no reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_q   <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head_q <= head_nxt;
      if (wr_en && !wr_acc && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

module bus_term_fifo #(
  parameter int         pckg_sz  = 16,
  parameter int         depth    = 8,
  parameter int         rx_depth = 8,
  parameter logic [7:0] id       = 8'd0,
  parameter int         cnt_w    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_vld,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic [cnt_w-1:0]   tx_drop,
  output logic [cnt_w-1:0]   rx_drop,
  output logic               misaddr
);
  logic       rx_full, rx_acc;
  logic [7:0] dst;

  term_fifo #(.W(pckg_sz), .DEPTH(depth), .CNT_W(cnt_w)) u_tx (
    .clk(clk), .rst(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
    .full(full), .vld(pndng), .head(D_pop), .drop_cnt(tx_drop)
  );

  term_fifo #(.W(pckg_sz), .DEPTH(rx_depth), .CNT_W(cnt_w)) u_rx (
    .clk(clk), .rst(reset), .wr_en(push), .wr_data(D_push), .rd_en(rx_rd),
    .full(rx_full), .vld(rx_vld), .head(rx_data), .drop_cnt(rx_drop)
  );

  // Only pushes that the RX FIFO actually stores are address-checked.
  assign rx_acc = push && (!rx_full || (rx_rd && rx_vld));
  assign dst    = D_push[pckg_sz-1 -: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaddr <= 1'b0;
    else if (rx_acc && (dst != id)) misaddr <= 1'b1;
  end
endmodule

// File: tb/tb_bus_term_fifo.sv
// Self-checking bench for bus_term_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.

module tb_bus_term_fifo;
  localparam int         W        = 16;
  localparam int         DEPTH    = 8;
  localparam int         RX_DEPTH = 8;
  localparam int         CNT_W    = 16;
  localparam logic [7:0] ID       = 8'd2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
  logic [W-1:0]     wr_data = '0, D_push = '0;
  logic             full, pndng, rx_vld, misaddr;
  logic [W-1:0]     D_pop, rx_data;
  logic [CNT_W-1:0] tx_drop, rx_drop;

  bus_term_fifo #(.pckg_sz(W), .depth(DEPTH), .rx_depth(RX_DEPTH), .id(ID), .cnt_w(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .pndng(pndng),
    .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push), .rx_vld(rx_vld), .rx_data(rx_data),
    .rx_rd(rx_rd), .tx_drop(tx_drop), .rx_drop(rx_drop), .misaddr(misaddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues and counters following the FIFO rules.
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  int           exp_tx_drop = 0;
  int           exp_rx_drop = 0;
  bit           exp_mis = 1'b0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    exp_tx_drop = 0;
    exp_rx_drop = 0;
    exp_mis     = 1'b0;
  endtask

  task automatic check_all();
    check("full",    32'(full),    32'(tx_q.size() == DEPTH));
    check("pndng",   32'(pndng),   32'(tx_q.size() != 0));
    check("D_pop",   32'(D_pop),   (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
    check("rx_vld",  32'(rx_vld),  32'(rx_q.size() != 0));
    check("rx_data", 32'(rx_data), (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'h0);
    check("tx_drop", 32'(tx_drop), 32'(exp_tx_drop));
    check("rx_drop", 32'(rx_drop), 32'(exp_rx_drop));
    check("misaddr", 32'(misaddr), 32'(exp_mis));
  endtask

  // One clock: compare outputs, drive inputs on the falling edge, update the model at the rising edge.
  task automatic cycle(input logic w, input logic [W-1:0] wd, input logic p,
                       input logic ps, input logic [W-1:0] dp, input logic rr);
    bit tx_pop, rx_pop, tx_room, rx_room;
    @(negedge clk);
    check_all();
    wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rx_rd = rr;
    @(posedge clk);
    tx_pop  = p && (tx_q.size() != 0);
    rx_pop  = rr && (rx_q.size() != 0);
    tx_room = (tx_q.size() < DEPTH) || tx_pop;
    rx_room = (rx_q.size() < RX_DEPTH) || rx_pop;
    if (tx_pop) void'(tx_q.pop_front());
    if (rx_pop) void'(rx_q.pop_front());
    if (w) begin
      if (tx_room) tx_q.push_back(wd);
      else if (exp_tx_drop < CNT_MAX) exp_tx_drop++;
    end
    if (ps) begin
      if (rx_room) begin
        rx_q.push_back(dp);
        if (dp[W-1 -: 8] != ID) exp_mis = 1'b1;
      end else if (exp_rx_drop < CNT_MAX) exp_rx_drop++;
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; wr_data = '0; D_push = '0;
    model_clear();
    #1 check_all();
    repeat (n) @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    // Reset held for five cycles.
    do_reset(5);

    // Ordering through the TX FIFO.
    cycle(1'b1, 16'h0101, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0202, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0303, 1'b0, 1'b0, '0, 1'b0);
    #1 check("ord_head0", 32'(D_pop), 32'h0101);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    #1 check("ord_head1", 32'(D_pop), 32'h0202);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    #1 check("ord_head2", 32'(D_pop), 32'h0303);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    #1 check("ord_empty", 32'(pndng), 32'h0);
    // Pop on empty is ignored.
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();

    // TX overflow: ten writes, no pops.
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0, '0, 1'b0);
      if (k == 8) #1 check("ovf_full8", 32'(full), 32'h1);
    end
    #1 check("ovf_drop", 32'(tx_drop), 32'd2);

    // Full with simultaneous write and pop: no drop, stays full.
    cycle(1'b1, 16'h1009, 1'b1, 1'b0, '0, 1'b0);
    #1 check("sim_full", 32'(full), 32'h1);
    check("sim_drop", 32'(tx_drop), 32'd2);
    check("sim_head", 32'(D_pop), 32'h1002);
    for (int k = 2; k <= 9; k++) begin
      #1 check("drain_head", 32'(D_pop), 32'h1000 + 32'(k));
      cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    #1 check("drain_empty", 32'(pndng), 32'h0);

    // Write and pop on an empty FIFO: write only.
    cycle(1'b1, 16'h0A0A, 1'b1, 1'b0, '0, 1'b0);
    #1 check("wr_pop_empty", 32'(D_pop), 32'h0A0A);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // RX overflow with a foreign destination.
    for (int k = 0; k < 9; k++) cycle(1'b0, '0, 1'b0, 1'b1, 16'h0155, 1'b0);
    #1 check("rx_ovf_drop", 32'(rx_drop), 32'd1);
    check("rx_ovf_mis", 32'(misaddr), 32'h1);
    check("rx_ovf_vld", 32'(rx_vld), 32'h1);
    for (int k = 0; k < 8; k++) begin
      #1 check("rx_drain", 32'(rx_data), 32'h0155);
      cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    end
    #1 check("rx_drained", 32'(rx_vld), 32'h0);

    // Reset mid-burst with three packets queued.
    for (int k = 0; k < 3; k++) cycle(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b1, 16'h0277, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0; push = 1'b0;
    #1 check("rst_pndng", 32'(pndng), 32'h0);
    check("rst_dpop", 32'(D_pop), 32'h0);
    check("rst_misaddr", 32'(misaddr), 32'h0);
    model_clear();
    do_reset(2);

    // Randomized traffic in phases with differing write/read pressure.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      logic [W-1:0] dp;
      case ((i / 300) % 4)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        2: begin wp = 95; rp = 95; end
        default: begin wp = 50; rp = 50; end
      endcase
      dp = 16'($urandom);
      if ($urandom_range(0, 19) != 0) dp[W-1 -: 8] = ID;
      cycle(1'($urandom_range(0, 99) < wp), 16'($urandom), 1'($urandom_range(0, 99) < rp),
            1'($urandom_range(0, 99) < wp), dp, 1'($urandom_range(0, 99) < rp));
      if (i == 1500) do_reset(1);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
